// File: rtl/uart_rx_bank_if.sv
// uart_rx_bank_if: host-side read/status port of the UART receiver bank
interface uart_rx_bank_if #(parameter int NCH = 4, parameter int DBITS = 8);
  localparam int SW = $clog2(NCH);
  logic [SW-1:0] sel;
  logic pull;
  logic clr;
  logic [DBITS-1:0] dout;
  logic [NCH-1:0] rx_empty;
  logic [NCH-1:0] rx_full;
  logic [NCH-1:0] frame_err;
  logic [NCH-1:0] overrun;
  modport master(output sel, pull, clr, input dout, rx_empty, rx_full, frame_err, overrun);
  modport slave(input sel, pull, clr, output dout, rx_empty, rx_full, frame_err, overrun);
endinterface

// File: rtl/uart_rx_bank.sv
// uart_rx_bank: NCH-channel UART receiver with per-channel FIFOs and a select/pull read port
module uart_rx_bank #(
  parameter int NCH = 4,
  parameter int DBITS = 8,
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DIV_W-1:0] div,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   rx,
  uart_rx_bank_if.slave    bus
);
  localparam int SW = $clog2(NCH);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(DBITS + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
  logic [DBITS-1:0] head [NCH];
  logic [NCH-1:0] empty_v, full_v, fe_v, ov_v;
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic s1, s, sp;
    state_t st;
    logic [DIV_W-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DBITS-1:0] sh;
    logic [DBITS-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic tick, push, ferr, pop, wr, fe, ov;
    assign tick = cnt == '0;
    assign push = en[i] && st == STOP && tick && s;
    assign ferr = en[i] && st == STOP && tick && !s;
    assign empty_v[i] = wp == rp;
    assign full_v[i] = (wp ^ rp) == {1'b1, {AW{1'b0}}};
    assign pop = bus.pull && bus.sel == SW'(i) && !empty_v[i];
    // a push into a full FIFO only lands when a pop frees the slot in the same cycle
    assign wr = push && (!full_v[i] || pop);
    assign head[i] = mem[rp[AW-1:0]];
    assign fe_v[i] = fe;
    assign ov_v[i] = ov;
    // two-stage synchroniser plus one stage of history for falling-edge detection
    always_ff @(posedge clk or negedge reset)
      if (!reset) {s1, s, sp} <= '1;
      else {s1, s, sp} <= {rx[i], s1, s};
    // frame FSM: mid-bit start validation, LSB-first data, stop-bit framing check
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        st <= IDLE;
        cnt <= '0;
        idx <= '0;
        sh <= '0;
      end else if (!en[i]) begin
        st <= IDLE;
        cnt <= '0;
      end else case (st)
        IDLE: if (sp && !s) begin
          cnt <= div >> 1;
          st <= START;
        end
        START: if (!tick) cnt <= cnt - 1'b1;
          else if (s) st <= IDLE;
          else begin
            cnt <= div;
            idx <= '0;
            st <= DATA;
          end
        DATA: if (!tick) cnt <= cnt - 1'b1;
          else begin
            sh <= {s, sh[DBITS-1:1]};
            cnt <= div;
            idx <= idx + 1'b1;
            st <= idx == IW'(DBITS - 1) ? STOP : DATA;
          end
        STOP: if (!tick) cnt <= cnt - 1'b1;
          else st <= s ? IDLE : WAITHI;
        WAITHI: if (s) st <= IDLE;
        default: st <= IDLE;
      endcase
    // FIFO storage, not reset: contents are only visible through valid pointers
    always_ff @(posedge clk)
      if (wr) mem[wp[AW-1:0]] <= sh;
    // FIFO pointers and sticky flags; a new error outranks a same-cycle clear
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        wp <= '0;
        rp <= '0;
        fe <= 1'b0;
        ov <= 1'b0;
      end else begin
        wp <= wr ? wp + 1'b1 : wp;
        rp <= pop ? rp + 1'b1 : rp;
        fe <= ferr || (fe && !bus.clr);
        ov <= (push && !wr) || (ov && !bus.clr);
      end
  end
  assign bus.rx_empty = empty_v;
  assign bus.rx_full = full_v;
  assign bus.frame_err = fe_v;
  assign bus.overrun = ov_v;
  // read port: dout holds the last word popped; pulls on an empty channel leave it alone
  always_ff @(posedge clk or negedge reset)
    if (!reset) bus.dout <= '0;
    else if (bus.pull && !empty_v[bus.sel]) bus.dout <= head[bus.sel];
endmodule

// File: tb/tb_uart_rx_bank.sv
// tb_uart_rx_bank: directed vector bench for the UART receiver bank
module tb_uart_rx_bank;
  logic clk = 1'b0;
  logic reset;
  logic [15:0] div;
  logic [3:0] en, rx;
  int n = 0;
  int err = 0;
  uart_rx_bank_if #(.NCH(4), .DBITS(8)) bus();
  uart_rx_bank #(.NCH(4), .DBITS(8), .DEPTH(4), .DIV_W(16)) dut (
    .clk(clk), .reset(reset), .div(div), .en(en), .rx(rx), .bus(bus)
  );
  always #5 clk = ~clk;
  typedef struct {
    int ch;
    logic [7:0] data;
    logic stp;
    logic [7:0] exp;
    logic fe;
  } vec_t;
  vec_t v[6];
  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // one frame per masked channel in lockstep, 8 clocks per bit at div = 7
  task automatic send(input logic [3:0] m, input logic [7:0] w0, w1, w2, w3, input logic stp);
    logic [7:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < 4; c++)
        if (m[c]) rx[c] = b == 0 ? 1'b0 : b == 9 ? stp : w[c][b-1];
      cyc(8);
    end
  endtask
  task automatic pull_chk(input int c, input logic [7:0] e, input string nm);
    bus.sel = c[1:0];
    bus.pull = 1'b1;
    cyc(1);
    bus.pull = 1'b0;
    chk(nm, bus.dout, e);
  endtask
  task automatic clr_pulse();
    bus.clr = 1'b1;
    cyc(1);
    bus.clr = 1'b0;
  endtask
  initial begin
    v[0] = '{0, 8'h55, 1'b1, 8'h55, 1'b0};
    v[1] = '{1, 8'h00, 1'b1, 8'h00, 1'b0};
    v[2] = '{2, 8'hFF, 1'b1, 8'hFF, 1'b0};
    v[3] = '{3, 8'h81, 1'b1, 8'h81, 1'b0};
    v[4] = '{2, 8'hA3, 1'b0, 8'h00, 1'b1};
    v[5] = '{2, 8'h5A, 1'b1, 8'h5A, 1'b0};
    reset = 1'b0; div = 16'd7; en = 4'hF; rx = 4'hF;
    bus.sel = '0; bus.pull = 1'b0; bus.clr = 1'b0;
    cyc(3);
    reset = 1'b1;
    cyc(3);
    chk("reset empty", bus.rx_empty, 4'hF);
    chk("reset full", bus.rx_full, 4'h0);
    chk("reset ferr", bus.frame_err, 4'h0);
    chk("reset ovr", bus.overrun, 4'h0);
    chk("reset dout", bus.dout, 8'h00);
    // table: single frames, one with a low stop bit
    for (int k = 0; k < 6; k++) begin
      send(4'b1 << v[k].ch, v[k].data, v[k].data, v[k].data, v[k].data, v[k].stp);
      cyc(2);
      chk($sformatf("v%0d ferr", k), bus.frame_err[v[k].ch], v[k].fe);
      chk($sformatf("v%0d empty", k), bus.rx_empty[v[k].ch], !v[k].stp);
      if (v[k].stp) begin
        pull_chk(v[k].ch, v[k].exp, $sformatf("v%0d dout", k));
        chk($sformatf("v%0d drained", k), bus.rx_empty[v[k].ch], 1'b1);
      end else begin
        cyc(16);
        chk($sformatf("v%0d break empty", k), bus.rx_empty[v[k].ch], 1'b1);
        rx[v[k].ch] = 1'b1;
        cyc(4);
        clr_pulse();
        chk($sformatf("v%0d clr", k), bus.frame_err[v[k].ch], 1'b0);
      end
    end
    // 2-clock glitch on ch1 must be rejected as a false start
    rx[1] = 1'b0;
    cyc(2);
    rx[1] = 1'b1;
    cyc(20);
    chk("glitch empty", bus.rx_empty, 4'hF);
    chk("glitch ferr", bus.frame_err, 4'h0);
    chk("glitch ovr", bus.overrun, 4'h0);
    // pull on empty channel leaves dout alone
    pull_chk(1, 8'h5A, "empty pull");
    // fill ch3, then overflow it
    for (int k = 1; k <= 4; k++) send(4'b1000, 0, 0, 0, 8'(k), 1'b1);
    cyc(2);
    chk("ch3 full", bus.rx_full[3], 1'b1);
    chk("ch3 no ovr yet", bus.overrun[3], 1'b0);
    send(4'b1000, 0, 0, 0, 8'h05, 1'b1);
    cyc(2);
    chk("ch3 ovr", bus.overrun[3], 1'b1);
    chk("ch3 still full", bus.rx_full[3], 1'b1);
    clr_pulse();
    chk("ch3 ovr clr", bus.overrun[3], 1'b0);
    // push and pull landing on the same edge of a full FIFO
    fork
      send(4'b1000, 0, 0, 0, 8'h06, 1'b1);
      begin
        cyc(78);
        bus.sel = 2'd3;
        bus.pull = 1'b1;
        cyc(1);
        bus.pull = 1'b0;
      end
    join
    cyc(2);
    chk("simul dout", bus.dout, 8'h01);
    chk("simul full", bus.rx_full[3], 1'b1);
    chk("simul no ovr", bus.overrun[3], 1'b0);
    pull_chk(3, 8'h02, "ch3 pop2");
    pull_chk(3, 8'h03, "ch3 pop3");
    pull_chk(3, 8'h04, "ch3 pop4");
    pull_chk(3, 8'h06, "ch3 pop6");
    chk("ch3 empty", bus.rx_empty[3], 1'b1);
    chk("ch3 not full", bus.rx_full[3], 1'b0);
    // all channels concurrently, drained with back-to-back pulls
    send(4'hF, 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    cyc(2);
    chk("all loaded", bus.rx_empty, 4'h0);
    bus.pull = 1'b1;
    for (int c = 0; c < 4; c++) begin
      bus.sel = 2'(c);
      cyc(1);
      chk($sformatf("rr ch%0d", c), bus.dout, 8'h11 * (c + 1));
    end
    bus.pull = 1'b0;
    chk("all drained", bus.rx_empty, 4'hF);
    // disabled channel ignores traffic
    en[1] = 1'b0;
    send(4'b0010, 0, 8'h77, 0, 0, 1'b1);
    cyc(2);
    chk("disabled empty", bus.rx_empty[1], 1'b1);
    en[1] = 1'b1;
    // reset in the middle of a ch0 data phase, with state elsewhere
    send(4'b0010, 0, 8'h99, 0, 0, 1'b0);
    rx[1] = 1'b1;
    pull_chk(2, 8'h44, "pre-reset dout");
    send(4'b0100, 0, 0, 8'h12, 0, 1'b1);
    rx[0] = 1'b0;
    cyc(8);
    rx[0] = 1'b1;
    cyc(10);
    reset = 1'b0;
    #1;
    chk("mid reset empty", bus.rx_empty, 4'hF);
    chk("mid reset ferr", bus.frame_err, 4'h0);
    chk("mid reset dout", bus.dout, 8'h00);
    chk("mid reset full", bus.rx_full, 4'h0);
    cyc(3);
    reset = 1'b1;
    cyc(3);
    send(4'b0001, 8'h3C, 0, 0, 0, 1'b1);
    cyc(2);
    pull_chk(0, 8'h3C, "post reset frame");
    chk("post reset empty", bus.rx_empty[0], 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
